b200_spi_sched: RTL and testbench

Arbitrating SPI master for the shared radio control SPI bus. It carries the AD9361 on `sen[0]` and the ADF4001 reference PLL on `sen[1]`, with spare selects `sen[7:2]`. Two independent requesters (host settings bus and an on-chip autonomous loader) issue whole SPI transactions; the block grants them round-robin, serialises each one MSB-first, and returns captured MISO bits. It sits on `bus_clk` between `b200_core` control logic and the top-level chip-select/SCLK/MOSI gating.

---
 rtl/b200_spi_sched.sv | 250 +++++++++++++++++++++++++
 tb/tb_b200_spi_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b200_spi_sched.sv
// b200_spi_sched: round-robin arbitrated SPI master for the shared radio
// control bus (AD9361 on sen[0], ADF4001 on sen[1], spares on sen[7:2]).
// Two requesters hand over whole transactions; each is shifted out MSB-first
// with CPOL=0 and the captured MISO bits are returned right-justified.
// All outputs are registered, and they are updated together with the state
// register, so every output matches the state it belongs to.
module b200_spi_sched #(
    parameter int MAX_LEN = 32,
    parameter int DIV_W   = 16
) (
    input  logic               bus_clk,
    input  logic               bus_rst,
    input  logic [DIV_W-1:0]   clkdiv,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [2:0]         req0_sel,
    input  logic [5:0]         req0_len,
    input  logic [MAX_LEN-1:0] req0_data,
    output logic               rsp0_valid,
    output logic [MAX_LEN-1:0] rsp0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [2:0]         req1_sel,
    input  logic [5:0]         req1_len,
    input  logic [MAX_LEN-1:0] req1_data,
    output logic               rsp1_valid,
    output logic [MAX_LEN-1:0] rsp1_data,
    output logic [7:0]         sen,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               busy
);

    localparam logic [5:0]       LEN_MAX = 6'(MAX_LEN);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_DONE,
        ST_GAP
    } spi_state_t;

    // Requester ports gathered into arrays so both sides share one datapath
    logic [1:0]         req_valid;
    logic [2:0]         req_sel  [2];
    logic [5:0]         req_len  [2];
    logic [MAX_LEN-1:0] req_data [2];

    assign req_valid   = {req1_valid, req0_valid};
    assign req_sel[0]  = req0_sel;
    assign req_sel[1]  = req1_sel;
    assign req_len[0]  = req0_len;
    assign req_len[1]  = req1_len;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Control and datapath state
    spi_state_t         state_reg, state_next;
    logic [DIV_W-1:0]   phase_reg, phase_next;   // cycles left in phase, minus one
    logic [DIV_W-1:0]   half_reg,  half_next;    // latched half period, minus one
    logic [5:0]         bits_reg,  bits_next;    // bits still to clock
    logic [2:0]         sel_reg,   sel_next;
    logic               side_reg,  side_next;    // side being served
    logic               last_reg,  last_next;    // side served most recently
    logic [MAX_LEN-1:0] tx_reg,    tx_next;
    logic [MAX_LEN-1:0] rx_reg,    rx_next;

    // Registered outputs
    logic [1:0]         ready_reg,     ready_next;
    logic [1:0]         rsp_valid_reg, rsp_valid_next;
    logic [MAX_LEN-1:0] rsp_data_reg [2];
    logic [7:0]         sen_reg,   sen_next;
    logic               sclk_reg,  sclk_next;
    logic               mosi_reg,  mosi_next;
    logic               busy_reg,  busy_next;

    // Handshake decode: only one ready is ever high, so it names the side
    logic       accept;
    logic       acc_side;
    logic [5:0] acc_len_raw;
    logic [5:0] acc_len;
    logic       xfer_active;

    assign acc_side    = ready_reg[1];
    assign accept      = (state_reg == ST_IDLE) && ((ready_reg & req_valid) != 2'b00);
    assign acc_len_raw = req_len[acc_side];
    // A length of zero or beyond the register width means a full-width transfer
    assign acc_len     = ((acc_len_raw == 6'd0) || (acc_len_raw > LEN_MAX)) ? LEN_MAX : acc_len_raw;

    // Next-state and datapath sequencing
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        half_next  = half_reg;
        bits_next  = bits_reg;
        sel_next   = sel_reg;
        side_next  = side_reg;
        last_next  = last_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SETUP;
                    phase_next = clkdiv;
                    half_next  = clkdiv;
                    bits_next  = acc_len;
                    sel_next   = req_sel[acc_side];
                    side_next  = acc_side;
                    last_next  = acc_side;
                    tx_next    = req_data[acc_side];
                    rx_next    = '0;
                end
            end
            ST_SETUP: begin
                if (phase_reg == '0) begin
                    state_next = ST_HIGH;
                    phase_next = half_reg;
                end else begin
                    phase_next = phase_reg - DIV_ONE;
                end
            end
            ST_HIGH: begin
                if (phase_reg == '0) begin
                    // Sample at the end of the high phase; advance MOSI as SCLK falls
                    state_next = ST_LOW;
                    phase_next = half_reg;
                    rx_next    = {rx_reg[MAX_LEN-2:0], miso};
                    tx_next    = {tx_reg[MAX_LEN-2:0], 1'b0};
                    bits_next  = bits_reg - 6'd1;
                end else begin
                    phase_next = phase_reg - DIV_ONE;
                end
            end
            ST_LOW: begin
                if (phase_reg == '0) begin
                    // The low phase after the final bit doubles as CS hold time
                    state_next = (bits_reg != 6'd0) ? ST_HIGH : ST_DONE;
                    phase_next = half_reg;
                end else begin
                    phase_next = phase_reg - DIV_ONE;
                end
            end
            ST_DONE: begin
                state_next = ST_GAP;
                phase_next = half_reg;
            end
            ST_GAP: begin
                if (phase_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    phase_next = phase_reg - DIV_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, including the arbiter grant
    always_comb begin
        xfer_active = (state_next == ST_SETUP) || (state_next == ST_HIGH) || (state_next == ST_LOW);
        sclk_next   = (state_next == ST_HIGH);
        mosi_next   = xfer_active & tx_next[MAX_LEN-1];
        busy_next   = (state_next != ST_IDLE);
        ready_next  = 2'b00;
        if (state_next == ST_IDLE) begin
            // On a tie the side that was not served last gets the grant
            ready_next[0] = req_valid[0] && (!req_valid[1] || last_reg);
            ready_next[1] = req_valid[1] && (!req_valid[0] || !last_reg);
        end
    end

    // One chip-select line per slave index, low only while a transfer is active
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sen
            assign sen_next[gi] = ~(xfer_active && (sel_next == 3'(gi)));
        end
    endgenerate

    // Per-side completion pulse and response holding register
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_valid_next[gi] = (state_next == ST_DONE) && (side_reg == 1'(gi));

            // Response data updates only on this side's completion
            always_ff @(posedge bus_clk) begin
                if (bus_rst) begin
                    rsp_data_reg[gi] <= '0;
                end else if (rsp_valid_next[gi]) begin
                    rsp_data_reg[gi] <= rx_reg;
                end
            end
        end
    endgenerate

    // State, datapath and output registers
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= '0;
            half_reg      <= '0;
            bits_reg      <= '0;
            sel_reg       <= '0;
            side_reg      <= 1'b0;
            last_reg      <= 1'b1;
            tx_reg        <= '0;
            rx_reg        <= '0;
            ready_reg     <= 2'b00;
            rsp_valid_reg <= 2'b00;
            sen_reg       <= 8'hFF;
            sclk_reg      <= 1'b0;
            mosi_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            half_reg      <= half_next;
            bits_reg      <= bits_next;
            sel_reg       <= sel_next;
            side_reg      <= side_next;
            last_reg      <= last_next;
            tx_reg        <= tx_next;
            rx_reg        <= rx_next;
            ready_reg     <= ready_next;
            rsp_valid_reg <= rsp_valid_next;
            sen_reg       <= sen_next;
            sclk_reg      <= sclk_next;
            mosi_reg      <= mosi_next;
            busy_reg      <= busy_next;
        end
    end

    assign req0_ready = ready_reg[0];
    assign req1_ready = ready_reg[1];
    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp0_data  = rsp_data_reg[0];
    assign rsp1_data  = rsp_data_reg[1];
    assign sen        = sen_reg;
    assign sclk       = sclk_reg;
    assign mosi       = mosi_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_b200_spi_sched.sv
// tb_b200_spi_sched: scoreboard bench for the arbitrated SPI master.
// Accepted requests push an expected response; completions pop and compare.
module tb_b200_spi_sched;

    logic        bus_clk = 1'b0;
    logic        bus_rst;
    logic [15:0] clkdiv;
    logic        req0_valid, req0_ready, rsp0_valid;
    logic [2:0]  req0_sel;
    logic [5:0]  req0_len;
    logic [31:0] req0_data, rsp0_data;
    logic        req1_valid, req1_ready, rsp1_valid;
    logic [2:0]  req1_sel;
    logic [5:0]  req1_len;
    logic [31:0] req1_data, rsp1_data;
    logic [7:0]  sen;
    logic        sclk, mosi, miso, busy;
    logic        loop_en, miso_val;

    assign miso = loop_en ? mosi : miso_val;

    always #5 bus_clk = ~bus_clk;

    b200_spi_sched #(.MAX_LEN(32), .DIV_W(16)) dut (
        .bus_clk    (bus_clk),
        .bus_rst    (bus_rst),
        .clkdiv     (clkdiv),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sel   (req0_sel),
        .req0_len   (req0_len),
        .req0_data  (req0_data),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sel   (req1_sel),
        .req1_len   (req1_len),
        .req1_data  (req1_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .sen        (sen),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .busy       (busy)
    );

    int cyc = 0;
    always @(posedge bus_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int eff_len(input logic [5:0] l);
        return ((l == 6'd0) || (l > 6'd32)) ? 32 : int'(l);
    endfunction

    typedef struct {
        int          side;
        logic [31:0] rx;
        int          due;
        int          len;
        int          h;
        logic [31:0] mosi_w;
        logic [7:0]  sen_w;
    } exp_t;

    exp_t sb[$];
    int   acc_side_q[$];
    int   acc_cyc_q[$];

    // Monitor state for the transfer in flight
    bit          in_xfer = 0;
    int          rise_cnt, sen_low_cnt, sen_bad, phase_bad, hi_run, cur_h;
    int          inv_bad = 0;
    logic [31:0] mosi_bits;
    logic [7:0]  cur_sen;
    logic        prev_sclk = 1'b0;
    logic [31:0] last_rsp0 = '0;

    // Observe the bus half a cycle away from the active edge
    always @(negedge bus_clk) begin : mon
        exp_t        e;
        int          s, l_eff, obs_side;
        logic        got;
        logic [5:0]  l;
        logic [2:0]  sl;
        logic [31:0] d, mask, obs_data;
        if (bus_rst) begin
            in_xfer   = 0;
            prev_sclk = 1'b0;
        end else begin
            if ($countones(~sen) > 1) inv_bad++;
            if ((sen == 8'hFF) && sclk) inv_bad++;
            if (!busy && ((sen != 8'hFF) || sclk)) inv_bad++;
            if (req0_ready && req1_ready) inv_bad++;
            if (in_xfer) begin
                if (sen != 8'hFF) begin
                    sen_low_cnt++;
                    if (sen != cur_sen) sen_bad++;
                end
                if (sclk && !prev_sclk) begin
                    rise_cnt++;
                    mosi_bits = {mosi_bits[30:0], mosi};
                end
                if (sclk) hi_run++;
                if (!sclk && prev_sclk) begin
                    if (hi_run != cur_h) phase_bad++;
                    hi_run = 0;
                end
            end
            if (rsp0_valid || rsp1_valid) begin
                obs_side = (rsp0_valid && rsp1_valid) ? 2 : (rsp1_valid ? 1 : 0);
                obs_data = rsp1_valid ? rsp1_data : rsp0_data;
                $display("rsp side=%0d data=0x%08h cycle=%0d pulses=%0d", obs_side, obs_data, cyc, rise_cnt);
                if (sb.size() == 0) begin
                    chk_eq("rsp_expected", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk_eq("rsp_side",    64'(obs_side),    64'(e.side));
                    chk_eq("rsp_data",    64'(obs_data),    64'(e.rx));
                    chk_eq("rsp_cycle",   64'(cyc),         64'(e.due));
                    chk_eq("sclk_pulses", 64'(rise_cnt),    64'(e.len));
                    chk_eq("mosi_word",   64'(mosi_bits),   64'(e.mosi_w));
                    chk_eq("sen_cycles",  64'(sen_low_cnt), 64'(e.h + 2 * e.h * e.len));
                    chk_eq("sen_sel_bad", 64'(sen_bad),     64'd0);
                    chk_eq("sclk_phase",  64'(phase_bad),   64'd0);
                    if (e.side == 0) last_rsp0 = e.rx;
                end
                in_xfer = 0;
            end
            got = 1'b0;
            s   = 0;
            l   = '0;
            d   = '0;
            sl  = '0;
            if (req0_valid && req0_ready) begin
                got = 1'b1; s = 0; l = req0_len; d = req0_data; sl = req0_sel;
            end else if (req1_valid && req1_ready) begin
                got = 1'b1; s = 1; l = req1_len; d = req1_data; sl = req1_sel;
            end
            if (got) begin
                l_eff    = eff_len(l);
                mask     = (l_eff == 32) ? 32'hFFFF_FFFF : ((32'd1 << l_eff) - 32'd1);
                e.side   = s;
                e.len    = l_eff;
                e.h      = int'(clkdiv) + 1;
                e.mosi_w = d >> (32 - l_eff);
                e.rx     = loop_en ? e.mosi_w : (miso_val ? mask : 32'h0);
                e.sen_w  = ~(8'd1 << sl);
                e.due    = cyc + 1 + e.h + 2 * e.h * l_eff;
                sb.push_back(e);
                acc_side_q.push_back(s);
                acc_cyc_q.push_back(cyc);
                in_xfer     = 1;
                rise_cnt    = 0;
                sen_low_cnt = 0;
                sen_bad     = 0;
                phase_bad   = 0;
                hi_run      = 0;
                mosi_bits   = '0;
                cur_h       = e.h;
                cur_sen     = e.sen_w;
            end
            prev_sclk = sclk;
        end
    end

    // Present one request, hold it until granted, then scramble clkdiv
    task automatic send(input int side, input logic [2:0] sel, input logic [5:0] len,
                        input logic [31:0] data, input logic [15:0] div);
        bit ok;
        ok     = 0;
        clkdiv = div;
        if (side == 0) begin
            req0_sel = sel; req0_len = len; req0_data = data; req0_valid = 1'b1;
        end else begin
            req1_sel = sel; req1_len = len; req1_data = data; req1_valid = 1'b1;
        end
        for (int i = 0; i < 400; i++) begin
            if ((side == 0 && req0_ready) || (side == 1 && req1_ready)) begin
                ok = 1;
                @(posedge bus_clk); #1;
                break;
            end
            @(posedge bus_clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        clkdiv     = 16'($urandom_range(0, 9));
        chk_eq("grant", 64'(ok), 64'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
            @(posedge bus_clk); #1;
        end
        chk_eq("done", 64'(ok), 64'd1);
    endtask

    task automatic wait_accepts(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (acc_side_q.size() >= n) begin
                ok = 1;
                break;
            end
            @(posedge bus_clk); #1;
        end
        chk_eq("accepts", 64'(ok), 64'd1);
    endtask

    initial begin
        bus_rst    = 1'b1;
        clkdiv     = '0;
        req0_valid = 1'b0; req0_sel = '0; req0_len = '0; req0_data = '0;
        req1_valid = 1'b0; req1_sel = '0; req1_len = '0; req1_data = '0;
        loop_en    = 1'b0;
        miso_val   = 1'b1;
        repeat (3) @(posedge bus_clk);
        #1;
        chk_eq("rst_sen",   64'(sen),                      64'hFF);
        chk_eq("rst_sclk",  64'(sclk),                     64'd0);
        chk_eq("rst_mosi",  64'(mosi),                     64'd0);
        chk_eq("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        chk_eq("rst_rspv",  64'({rsp1_valid, rsp0_valid}), 64'd0);
        chk_eq("rst_rspd",  64'({rsp1_data, rsp0_data}),   64'd0);
        chk_eq("rst_busy",  64'(busy),                     64'd0);
        bus_rst = 1'b0;
        @(posedge bus_clk); #1;

        // Tie with both sides held valid: strict alternation, 20-cycle spacing
        acc_side_q.delete();
        acc_cyc_q.delete();
        clkdiv   = 16'd0;
        req0_sel = 3'd0; req0_len = 6'd8; req0_data = 32'h1100_0000;
        req1_sel = 3'd2; req1_len = 6'd8; req1_data = 32'h2200_0000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_accepts(3);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done();
        if (acc_side_q.size() >= 3) begin
            chk_eq("tie_first",  64'(acc_side_q[0]), 64'd0);
            chk_eq("tie_second", 64'(acc_side_q[1]), 64'd1);
            chk_eq("tie_third",  64'(acc_side_q[2]), 64'd0);
            chk_eq("tie_gap01",  64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd20);
            chk_eq("tie_gap12",  64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd20);
        end

        // Basic 24-bit write with MISO tied high
        loop_en  = 1'b0;
        miso_val = 1'b1;
        send(0, 3'd0, 6'd24, 32'hABCD_EF00, 16'd0);
        wait_done();

        // Loopback with H=4 on the PLL select
        loop_en = 1'b1;
        send(1, 3'd1, 6'd8, 32'h5A00_0000, 16'd3);
        wait_done();
        chk_eq("loop_rsp1", 64'(rsp1_data), 64'h0000_005A);

        // Length boundaries: 0 and 40 mean 32, 1 is a single bit
        send(0, 3'd3, 6'd0,  $urandom, 16'd0);
        wait_done();
        send(1, 3'd4, 6'd40, $urandom, 16'd1);
        wait_done();
        send(0, 3'd5, 6'd1,  32'h8000_0000, 16'd0);
        wait_done();

        // Select sweep across both sides, mixed MISO sources and dividers
        for (int s = 0; s < 8; s++) begin
            loop_en  = s[0];
            miso_val = s[1];
            send(s % 2, 3'(s), 6'(4 + s), $urandom, 16'(s % 3));
            wait_done();
        end
        chk_eq("rsp0_hold", 64'(rsp0_data), 64'(last_rsp0));

        // Reset in the middle of a 24-bit transfer
        loop_en  = 1'b0;
        miso_val = 1'b1;
        send(0, 3'd0, 6'd24, 32'hC3C3_C300, 16'd0);
        for (int i = 0; i < 500; i++) begin
            if (rise_cnt >= 5) break;
            @(posedge bus_clk); #1;
        end
        chk_eq("mid_bits", 64'(rise_cnt), 64'd5);
        bus_rst = 1'b1;
        sb.delete();
        @(posedge bus_clk); #1;
        chk_eq("mid_sen",  64'(sen),                      64'hFF);
        chk_eq("mid_sclk", 64'(sclk),                     64'd0);
        chk_eq("mid_rspv", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        chk_eq("mid_busy", 64'(busy),                     64'd0);
        @(posedge bus_clk); #1;
        bus_rst = 1'b0;
        repeat (60) begin
            @(posedge bus_clk); #1;
        end
        chk_eq("mid_rspd", 64'(rsp0_data), 64'd0);

        // First tie after reset goes to requester 0 again
        acc_side_q.delete();
        acc_cyc_q.delete();
        clkdiv   = 16'd0;
        req0_sel = 3'd6; req0_len = 6'd4; req0_data = 32'h9000_0000;
        req1_sel = 3'd7; req1_len = 6'd4; req1_data = 32'h6000_0000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_accepts(1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done();
        if (acc_side_q.size() >= 1) chk_eq("rst_tie_first", 64'(acc_side_q[0]), 64'd0);

        repeat (5) @(posedge bus_clk);
        #1;
        chk_eq("sb_empty", 64'(sb.size()), 64'd0);
        chk_eq("bus_inv",  64'(inv_bad),   64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
